// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier and its writeback consumers.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam logic [1:0] MD_PAIR   = 2'b11;
  localparam logic [1:0] MD_SINGLE = 2'b00;
  localparam int         MUL_STEPS = 32;

  // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    mag = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_unit.sv
// 32x32 shift-add multiplier: one partial product per cycle, 64-bit product
// presented for one cycle together with the register-file writeback controls.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         dest,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [4:0]         da_out,
  output logic               rw_out,
  output logic [1:0]         md_out
);

  mul_state_e         state_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, result_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [4:0]         cnt_q, dest_q, da_q;
  logic               neg_q, busy_q, done_q, rw_q;
  logic [1:0]         md_q;
  logic [2*WIDTH-1:0] acc_d;

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      da_q     <= '0;
      rw_q     <= 1'b0;
      md_q     <= MD_SINGLE;
    end else begin
      // Writeback outputs are only live for the single cycle after DONE.
      done_q   <= 1'b0;
      result_q <= '0;
      da_q     <= '0;
      rw_q     <= 1'b0;
      md_q     <= MD_SINGLE;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= start;
          if (start) begin
            state_q  <= ST_CALC;
            mcand_q  <= {{WIDTH{1'b0}}, mag(a, sign)};
            mplier_q <= mag(b, sign);
            neg_q    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            dest_q   <= dest;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        ST_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'(MUL_STEPS - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q   <= 1'b1;
          result_q <= neg_q ? (~acc_q + 64'd1) : acc_q;
          da_q     <= dest_q;
          // DA+1 wraps to R0 for dest 31, so that case writes the low word only.
          rw_q     <= (dest_q != 5'd0);
          md_q     <= (dest_q == 5'd0 || dest_q == 5'd31) ? MD_SINGLE : MD_PAIR;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign da_out = da_q;
  assign rw_out = rw_q;
  assign md_out = md_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed and random checks of mul_unit against an arithmetic reference product.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sign = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  dest = '0;
  logic        busy, done, rw_out;
  logic [63:0] result;
  logic [4:0]  da_out;
  logic [1:0]  md_out;

  int checks = 0;
  int errors = 0;

  mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst_n), .start(start), .sign(sign), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .result(result), .da_out(da_out), .rw_out(rw_out),
    .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [4:0] d,
                       input logic s);
    a = x; b = y; dest = d; sign = s; start = 1'b1;
  endtask

  // mode 0: plain, 1: start glitches at edges 5 and 33, 2: next op held from edge 1.
  // skip0: edge 0 already happened (caller accepted on the previous op's edge 34).
  task automatic watch(input logic [63:0] exp, input logic [4:0] d, input int mode,
                       input bit skip0);
    if (!skip0) @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      chk("done", 64'(done), 64'(k == 33));
      chk("busy", 64'(busy), 64'(k < 34 || mode == 2));
      if (k == 33) begin
        chk("result", result, exp);
        chk("da_out", 64'(da_out), 64'(d));
        chk("rw_out", 64'(rw_out), 64'(d != 0));
        if (d != 0) chk("md_out", 64'(md_out), (d == 31) ? 64'd0 : 64'd3);
      end else begin
        chk("result_idle", result, 64'd0);
        chk("rw_idle", 64'(rw_out), 64'd0);
      end
      if (mode == 1 && (k == 4 || k == 32))
        drive($urandom, $urandom, 5'($urandom_range(1, 30)), 1'($urandom));
      if (mode == 1 && (k == 5 || k == 33)) start = 1'b0;
      if (mode == 2 && k == 34) start = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] x, y;
    logic [4:0]  d;
    logic        s;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_da", 64'(da_out), 64'd0);
    chk("rst_rw", 64'(rw_out), 64'd0);
    chk("rst_md", 64'(md_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    watch(64'hFFFF_FFFE_0000_0001, 5'd4, 0, 0);
    drive(32'hFFFF_FFFD, 32'h0000_0007, 5'd6, 1'b1);
    watch(64'hFFFF_FFFF_FFFF_FFEB, 5'd6, 0, 0);
    drive(32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1);
    watch(64'h4000_0000_0000_0000, 5'd9, 0, 0);
    drive(32'd5, 32'd6, 5'd31, 1'b0);
    watch(64'd30, 5'd31, 0, 0);
    drive(32'd5, 32'd6, 5'd0, 1'b0);
    watch(64'd30, 5'd0, 0, 0);

    // Late start requests must not disturb the product in flight.
    drive(32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1);
    watch(ref_prod(32'h1234_5678, 32'h9ABC_DEF0, 1'b1), 5'd12, 1, 0);

    // Asynchronous abort: reset falls just before edge 10 and releases after it.
    drive(32'd1000, 32'd1000, 5'd3, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy2", 64'(busy), 64'd0);
    drive(32'hDEAD_BEEF, 32'h0000_0101, 5'd7, 1'b0);
    watch(ref_prod(32'hDEAD_BEEF, 32'h0000_0101, 1'b0), 5'd7, 0, 0);

    // Back-to-back: second request held from edge 1, accepted at edge 34.
    drive(32'hFFFF_FFFF, 32'h0000_0002, 5'd20, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    drive(32'h7FFF_FFFF, 32'h8000_0000, 5'd21, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      chk("b2b_done", 64'(done), 64'(k == 33));
      chk("b2b_busy", 64'(busy), 64'd1);
      if (k == 33) chk("b2b_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    watch(ref_prod(32'h7FFF_FFFF, 32'h8000_0000, 1'b1), 5'd21, 0, 1);

    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      y = $urandom;
      if (i == 0) x = 32'h8000_0000;
      if (i == 1) y = 32'd0;
      d = 5'($urandom_range(0, 31));
      s = 1'($urandom);
      drive(x, y, d, s);
      watch(ref_prod(x, y, s), d, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Sequential 32×32 signed/unsigned shift-add multiplier for the execute stage. It accepts two operands and a destination register address, stalls the pipeline while it iterates, then presents a 64-bit product with register-file writeback controls. Its outputs feed the D-mux/writeback path directly: low word to the destination register, high word to the destination plus one.

## Interface
- `WIDTH`, 32: operand width. The product is 2×WIDTH. Only 32 is supported.
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply. Sampled only in IDLE.
- `sign`  in  1  1 = signed two's-complement operands; 0 = unsigned.
- `a`, `b`  in  32 each  multiplicand and multiplier.
- `dest`  in  5  destination register address for the low word.
- `busy`  out  1  pipeline stall request; high in CALC and DONE.
- `done`  out  1  one-cycle pulse; result and writeback controls are valid.
- `result`  out  64  product; drives the 64-bit writeback data bus.
- `da_out`  out  5  writeback destination address.
- `rw_out`  out  1  register write enable; valid only with `done`.
- `md_out`  out  2  `2'b11` = 64-bit paired write, `2'b00` = single low-word write.

## Operation
- Three-state FSM: IDLE → CALC → DONE → IDLE.
- IDLE to CALC when `start`=1:
  - Latch the magnitudes of `a` and `b`. In signed mode a negative operand is two's-complement negated; 0x80000000 becomes the unsigned value 2^31.
  - Latch `neg` = `sign` & (a[31] ^ b[31]).
  - Latch `dest`.
  - Clear the 64-bit accumulator and the 5-bit step counter.
- CALC, once per cycle:
  - If multiplier bit 0 = 1, add the multiplicand (64-bit, shifted left by the step count) into the accumulator.
  - Shift the multiplier right by 1.
  - Increment the counter.
  - After 32 steps (counter wraps 31→0), go to DONE.
- DONE, exactly one cycle:
  - `result` = `neg` ? −acc : acc, as a 64-bit two's-complement value.
  - `done`=1.
  - `da_out` = latched dest.
  - `rw_out` and `md_out` follow the destination rules below.
  - Then go to IDLE.
- Destination rules. These exist because the register file writes DA and DA+1 with a 5-bit wrap, and only DA is R0-protected.
  - dest = 0: `rw_out`=0; the product is discarded; `done` still pulses.
  - dest = 31: `rw_out`=1, `md_out`=00; only the low word is written, never R0.
  - otherwise: `rw_out`=1, `md_out`=11.
- `start` is ignored while `busy`=1, including the DONE cycle. There is no queueing.
- Operands are used only at the accept edge. Later changes on `a`, `b`, `dest` or `sign` have no effect.

## Timing
- Reset value of every output: `busy`=0, `done`=0, `result`=0, `da_out`=0, `rw_out`=0, `md_out`=00. FSM returns to IDLE.
- Outputs are registered. `rw_out`, `md_out`, `da_out` and `result` are nonzero only in the DONE cycle; they are 0 in all other cycles.
- Latency, counting from the edge that samples `start` as edge 0:
  - `busy` rises after edge 0.
  - `done` is high for the cycle following edge 33.
  - `busy` falls after edge 34.
- Throughput: one multiply per 34 cycles. The next `start` can be accepted at edge 34, i.e. the cycle in which `busy` has just fallen.
- Reset asserted mid-operation aborts immediately and asynchronously. No `done` pulse is produced and no write is issued. The first `start` after reset release is accepted normally.
- Arithmetic is exact for all operand pairs in both modes. There is no overflow because the result is 64 bits wide.

## Structure
- Shared package `mul_pkg`, holding:
  - FSM state encoding (IDLE, CALC, DONE);
  - `MD_PAIR` = 2'b11 and `MD_SINGLE` = 2'b00, shared with the register file and the D-mux;
  - `MUL_STEPS` = 32;
  - a magnitude/negate function.
- Single module; no sub-module is needed.
- The accumulator, multiplicand and multiplier shift registers live in the same always block as the FSM.

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF, dest=4 → at edge 33: `result`=0xFFFFFFFE_00000001, `md_out`=11, `rw_out`=1, `da_out`=4; `done` high for exactly one cycle.
- Signed −3 × 7 (0xFFFFFFFD, 0x00000007), dest=6 → `result`=0xFFFFFFFF_FFFFFFEB. Signed 0x80000000 × 0x80000000 → `result`=0x40000000_00000000.
- dest=31, unsigned 5×6 → `result`=30, `md_out`=00, `rw_out`=1. dest=0 → `done`=1, `rw_out`=0.
- `start` re-asserted with different operands at edges 5 and 33 → both ignored; the original product is delivered unchanged.
- Reset pulsed low at edge 10 of an operation → `busy`=0 and `done` never pulses. A new `start` at edge 12 yields a correct `done` 33 cycles later.
- Back-to-back: second `start` held continuously from edge 1 → accepted at edge 34; its `done` is high for the cycle following edge 67.
